alu_arbiter: RTL

//  Shares one logicALU instance between two requesters (e.g. issue port 0 and 1).

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu_arbiter_alu.sv | 35 +++
 rtl/alu_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and ALUControl encodings for the
// two-port ALU arbiter slice.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_ADD = 3'b011;
   localparam logic [2:0] ALU_SLR = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SAR = 3'b110;
   localparam logic [2:0] ALU_SC  = 3'b111;

   typedef enum logic {
      EMPTY,
      FULL
   } alu_buf_state_t;

   typedef logic req_id_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two issue
// ports, the shared ALU arbiter and writeback.
interface alu_arbiter_if #(
   parameter int N     = 32,
   parameter int CNT_W = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [N-1:0]     req0_a;
   logic [N-1:0]     req0_b;
   logic [2:0]       req0_ctrl;
   logic             req1_valid;
   logic             req1_ready;
   logic [N-1:0]     req1_a;
   logic [N-1:0]     req1_b;
   logic [2:0]       req1_ctrl;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [N-1:0]     rsp_result;
   logic             rsp_id;
   logic [CNT_W-1:0] op_count;

   modport master (
      output req0_valid, req0_a, req0_b, req0_ctrl,
      output req1_valid, req1_a, req1_b, req1_ctrl,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_result, rsp_id, op_count
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_ctrl,
      input  req1_valid, req1_a, req1_b, req1_ctrl,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_result, rsp_id, op_count
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational N-bit ALU; carries out of
// the top bit are dropped, shifts use b's low bits.
module logicALU
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   ctrl,
   output logic [N-1:0] result
);
   localparam int SW = $clog2(N);

   logic [SW-1:0] sh;
   logic          lt;

   assign sh = b[SW-1:0];
   assign lt = $signed(a) < $signed(b);

   always_comb begin
      result = '0;
      unique case (ctrl)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_ADD: result = a + b;
         ALU_SLR: result = a >> sh;
         ALU_SLL: result = a << sh;
         ALU_SAR: result = $signed(a) >>> sh;
         ALU_SC:  result = {{(N-1){1'b0}}, lt};
         default: result = '0;
      endcase
   end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two issue
// ports, with a one-entry registered result buffer.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N     = 32,
   parameter int CNT_W = 16
) (
   input logic         clk,
   input logic         reset,
   alu_arbiter_if.slave bus
);
   alu_buf_state_t   state_q, state_d;
   logic [N-1:0]     res_q;
   req_id_t          id_q;
   req_id_t          last_q;
   logic [CNT_W-1:0] cnt_q;

   logic         grant0, grant1;
   logic         can_accept, accept, drain;
   req_id_t      gid;
   logic [N-1:0] alu_a, alu_b, alu_y;
   logic [2:0]   alu_ctrl;

   always_comb begin
      grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
      grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
      gid    = grant1;
   end

   always_comb begin
      can_accept = (state_q == EMPTY) | bus.rsp_ready;
      accept     = (grant0 | grant1) & can_accept;
      drain      = (state_q == FULL) & bus.rsp_ready;
      state_d    = state_q;
      unique case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL:  if (accept) state_d = FULL;
                else if (bus.rsp_ready) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Ready is masked by reset so it drops without waiting for an edge.
   assign bus.req0_ready = grant0 & can_accept & ~reset;
   assign bus.req1_ready = grant1 & can_accept & ~reset;

   assign alu_a    = grant1 ? bus.req1_a    : bus.req0_a;
   assign alu_b    = grant1 ? bus.req1_b    : bus.req0_b;
   assign alu_ctrl = grant1 ? bus.req1_ctrl : bus.req0_ctrl;

   logicALU #(.N(N)) u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .ctrl   (alu_ctrl),
      .result (alu_y)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q  <= '0;
         id_q   <= 1'b0;
         last_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         if (accept) begin
            res_q  <= alu_y;
            id_q   <= gid;
            last_q <= gid;
         end
         if (drain) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.rsp_valid  = (state_q == FULL);
   assign bus.rsp_result = res_q;
   assign bus.rsp_id     = id_q;
   assign bus.op_count   = cnt_q;
endmodule
